// File: rtl/descriptor_dispatcher.sv
// Pops descriptors from a first-word-fall-through FIFO and hands each valid one to an idle
// action engine, round-robin, tracking per-engine busy state and dispatch/drop/completion counts.
module descriptor_dispatcher #(
  parameter int DATA_WIDTH  = 1024,
  parameter int PASID_WIDTH = 9,
  parameter int NUM_ENG     = 4,
  parameter int ENG_W       = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable_i,
  input  logic                   dsc_ready_i,
  input  logic [DATA_WIDTH-1:0]  dsc_data_i,
  output logic                   dsc_pull_o,
  output logic [NUM_ENG-1:0]     eng_valid_o,
  input  logic [NUM_ENG-1:0]     eng_ready_i,
  output logic [DATA_WIDTH-1:0]  eng_data_o,
  output logic [PASID_WIDTH-1:0] eng_pasid_o,
  input  logic [NUM_ENG-1:0]     eng_done_i,
  output logic [NUM_ENG-1:0]     eng_busy_o,
  output logic                   idle_o,
  output logic [CNT_WIDTH-1:0]   dispatched_cnt_o,
  output logic [CNT_WIDTH-1:0]   dropped_cnt_o,
  output logic [CNT_WIDTH-1:0]   completed_cnt_o
);

  localparam int                 PASID_LSB = 992;
  localparam logic [NUM_ENG-1:0] ENG_ONE   = NUM_ENG'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_SEND} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [ENG_W-1:0]        target_q, target_d;
  logic [ENG_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_ENG-1:0]      eng_valid_q, eng_valid_d;
  logic [NUM_ENG-1:0]      busy_q, busy_d;
  logic [CNT_WIDTH-1:0]    dispatched_q, dispatched_d;
  logic [CNT_WIDTH-1:0]    dropped_q, dropped_d;
  logic [CNT_WIDTH-1:0]    completed_q, completed_d;

  logic                    arb_found;
  logic [ENG_W-1:0]        arb_idx;
  logic [ENG_W:0]          cand;
  logic [NUM_ENG-1:0]      done_hit;
  logic [CNT_WIDTH-1:0]    done_cnt;
  logic                    drop_evt, grant_evt, accept_evt;

  // First free engine at or after rr_ptr; the descending scan lets the nearest candidate win.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = NUM_ENG - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (ENG_W + 1)'(k);
      if (cand >= (ENG_W + 1)'(NUM_ENG)) cand = cand - (ENG_W + 1)'(NUM_ENG);
      if (!busy_q[cand[ENG_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[ENG_W-1:0];
      end
    end
  end

  assign done_hit = eng_done_i & busy_q;

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_ENG; i++) done_cnt = done_cnt + CNT_WIDTH'(done_hit[i]);
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM output decode: pop strobe and the per-state events that steer the datapath
  always_comb begin
    dsc_pull_o = 1'b0;
    drop_evt   = 1'b0;
    grant_evt  = 1'b0;
    accept_evt = 1'b0;
    unique case (state_q)
      S_IDLE:  dsc_pull_o = enable_i & dsc_ready_i;
      S_ARB: begin
        drop_evt  = ~hold_q[0];
        grant_evt = hold_q[0] & arb_found;
      end
      S_SEND:  accept_evt = eng_ready_i[target_q];
      default: ;
    endcase
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (dsc_pull_o) state_d = S_ARB;
      S_ARB: begin
        if (drop_evt)       state_d = S_IDLE;
        else if (grant_evt) state_d = S_SEND;
      end
      S_SEND:  if (accept_evt) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hold_d       = dsc_pull_o ? dsc_data_i : hold_q;
    target_d     = grant_evt ? arb_idx : target_q;
    rr_ptr_d     = rr_ptr_q;
    eng_valid_d  = eng_valid_q;
    busy_d       = busy_q & ~done_hit;
    dispatched_d = dispatched_q + CNT_WIDTH'(accept_evt);
    dropped_d    = dropped_q + CNT_WIDTH'(drop_evt);
    completed_d  = completed_q + done_cnt;
    if (grant_evt) eng_valid_d = ENG_ONE << arb_idx;
    if (accept_evt) begin
      eng_valid_d      = '0;
      busy_d[target_q] = 1'b1;
      rr_ptr_d         = (target_q == ENG_W'(NUM_ENG - 1)) ? '0 : target_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the wide hold register is reset on purpose so the engine bus reads zero after reset.
      hold_q       <= '0;
      target_q     <= '0;
      rr_ptr_q     <= '0;
      eng_valid_q  <= '0;
      busy_q       <= '0;
      dispatched_q <= '0;
      dropped_q    <= '0;
      completed_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the same pre-edge values.
      hold_q       <= hold_d;
      target_q     <= target_d;
      rr_ptr_q     <= rr_ptr_d;
      eng_valid_q  <= eng_valid_d;
      busy_q       <= busy_d;
      dispatched_q <= dispatched_d;
      dropped_q    <= dropped_d;
      completed_q  <= completed_d;
    end
  end

  assign eng_valid_o      = eng_valid_q;
  assign eng_data_o       = hold_q;
  assign eng_pasid_o      = hold_q[PASID_LSB +: PASID_WIDTH];
  assign eng_busy_o       = busy_q;
  assign idle_o           = (state_q == S_IDLE) && (busy_q == '0);
  assign dispatched_cnt_o = dispatched_q;
  assign dropped_cnt_o    = dropped_q;
  assign completed_cnt_o  = completed_q;

endmodule

// File: tb/tb_descriptor_dispatcher.sv
// Directed bench for descriptor_dispatcher: dispatch order, drops, stall on full engines,
// held transfers under backpressure, completion accounting and asynchronous reset.
module tb_descriptor_dispatcher;

  localparam int DW = 1024;
  localparam int PW = 9;
  localparam int NE = 4;
  localparam int EW = 2;
  localparam int CW = 32;
  localparam logic [DW-1:0] GARB = {32{32'hDEADBEEF}};

  logic          clk = 1'b0;
  logic          resetn;
  logic          enable_i;
  logic          dsc_ready_i;
  logic [DW-1:0] dsc_data_i;
  logic          dsc_pull_o;
  logic [NE-1:0] eng_valid_o;
  logic [NE-1:0] eng_ready_i;
  logic [DW-1:0] eng_data_o;
  logic [PW-1:0] eng_pasid_o;
  logic [NE-1:0] eng_done_i;
  logic [NE-1:0] eng_busy_o;
  logic          idle_o;
  logic [CW-1:0] dispatched_cnt_o;
  logic [CW-1:0] dropped_cnt_o;
  logic [CW-1:0] completed_cnt_o;

  always #5 clk = ~clk;

  descriptor_dispatcher #(
    .DATA_WIDTH (DW),
    .PASID_WIDTH(PW),
    .NUM_ENG    (NE),
    .ENG_W      (EW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable_i        (enable_i),
    .dsc_ready_i     (dsc_ready_i),
    .dsc_data_i      (dsc_data_i),
    .dsc_pull_o      (dsc_pull_o),
    .eng_valid_o     (eng_valid_o),
    .eng_ready_i     (eng_ready_i),
    .eng_data_o      (eng_data_o),
    .eng_pasid_o     (eng_pasid_o),
    .eng_done_i      (eng_done_i),
    .eng_busy_o      (eng_busy_o),
    .idle_o          (idle_o),
    .dispatched_cnt_o(dispatched_cnt_o),
    .dropped_cnt_o   (dropped_cnt_o),
    .completed_cnt_o (completed_cnt_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [8:0] pasid, input logic [15:0] tag,
                                       input logic v);
    logic [DW-1:0] d;
    d             = '0;
    d[992 +: 9]   = pasid;
    d[991:960]    = {16'hC0DE, tag};
    d[63:0]       = {16'hA5A5, tag, 31'h0, v};
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one descriptor at the FIFO head until it is popped, then empties the FIFO.
  task automatic offer(input logic [DW-1:0] d, output int waited);
    bit got;
    got         = 1'b0;
    waited      = 0;
    dsc_data_i  = d;
    dsc_ready_i = 1'b1;
    while (!got && waited < 20) begin
      @(negedge clk);
      if (dsc_pull_o) got = 1'b1;
      else begin
        tick();
        waited++;
      end
    end
    check("offer_pull", 64'(got), 64'd1);
    tick();
    dsc_ready_i = 1'b0;
    dsc_data_i  = GARB;
  endtask

  // Returns at the falling edge where eng_valid_o is first seen high.
  task automatic wait_valid(output logic [NE-1:0] seen, output int waited);
    seen   = '0;
    waited = 0;
    while (seen == '0 && waited < 20) begin
      @(negedge clk);
      if (eng_valid_o != '0) seen = eng_valid_o;
      else begin
        tick();
        waited++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    logic [NE-1:0] seen;
    int            w, lat, bad;

    resetn      = 1'b0;
    enable_i    = 1'b0;
    dsc_ready_i = 1'b0;
    dsc_data_i  = '0;
    eng_ready_i = '0;
    eng_done_i  = '0;
    #12;
    check("rst_valid", 64'(eng_valid_o), 64'h0);
    check("rst_busy",  64'(eng_busy_o), 64'h0);
    check("rst_idle",  64'(idle_o), 64'h1);
    check("rst_pull",  64'(dsc_pull_o), 64'h0);
    check("rst_disp",  64'(dispatched_cnt_o), 64'h0);
    check("rst_drop",  64'(dropped_cnt_o), 64'h0);
    check("rst_comp",  64'(completed_cnt_o), 64'h0);
    check("rst_pasid", 64'(eng_pasid_o), 64'h0);
    tick();
    resetn = 1'b1;

    // Four valid descriptors, engines always ready: round-robin 0,1,2,3.
    enable_i    = 1'b1;
    eng_ready_i = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      d = mk(9'(5 + j), 16'(j + 1), 1'b1);
      offer(d, w);
      wait_valid(seen, lat);
      check($sformatf("t1_valid%0d", j), 64'(seen), 64'(4'b0001 << j));
      if (j == 0) check("t1_latency", 64'(lat), 64'd1);
      check($sformatf("t1_pasid%0d", j), 64'(eng_pasid_o), 64'(5 + j));
      check($sformatf("t1_data_lo%0d", j), eng_data_o[63:0], d[63:0]);
      check($sformatf("t1_data_hi%0d", j), eng_data_o[1023:960], d[1023:960]);
      tick();
    end
    check("t1_busy", 64'(eng_busy_o), 64'hF);
    check("t1_disp", 64'(dispatched_cnt_o), 64'd4);
    check("t1_idle", 64'(idle_o), 64'h0);

    // Invalid descriptor is dropped without touching any engine.
    offer(mk(9'h1AB, 16'h0BAD, 1'b0), w);
    @(negedge clk);
    check("t2_valid_arb", 64'(eng_valid_o), 64'h0);
    tick();
    check("t2_drop", 64'(dropped_cnt_o), 64'd1);
    check("t2_valid", 64'(eng_valid_o), 64'h0);
    check("t2_disp", 64'(dispatched_cnt_o), 64'd4);

    // All engines busy: descriptor waits; freeing engine 2 lets it through.
    offer(mk(9'h009, 16'h0005, 1'b1), w);
    check("t3_pull_immediate", 64'(w), 64'd0);
    dsc_ready_i = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (eng_valid_o != '0 || dsc_pull_o) bad++;
      tick();
    end
    check("t3_stall", 64'(bad), 64'd0);
    dsc_ready_i = 1'b0;
    eng_done_i  = 4'b0100;
    tick();
    eng_done_i  = '0;
    check("t3_comp", 64'(completed_cnt_o), 64'd1);
    check("t3_busy", 64'(eng_busy_o), 64'hB);
    wait_valid(seen, lat);
    check("t3_valid", 64'(seen), 64'h4);
    check("t3_lat", 64'(lat), 64'd1);
    check("t3_pasid", 64'(eng_pasid_o), 64'h009);
    tick();
    check("t3_disp", 64'(dispatched_cnt_o), 64'd5);
    check("t3_busy2", 64'(eng_busy_o), 64'hF);

    // Backpressure on target 0; a ready pulse on engine 1 must be ignored.
    eng_ready_i = '0;
    eng_done_i  = 4'b0001;
    tick();
    eng_done_i  = '0;
    check("t4_comp", 64'(completed_cnt_o), 64'd2);
    d = mk(9'h0AA, 16'h0044, 1'b1);
    offer(d, w);
    wait_valid(seen, lat);
    check("t4_valid", 64'(seen), 64'h1);
    tick();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      eng_ready_i = (c == 5) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (eng_valid_o !== 4'b0001 || eng_data_o !== d || eng_pasid_o !== 9'h0AA ||
          dispatched_cnt_o !== 32'd5) bad++;
      tick();
    end
    eng_ready_i = '0;
    check("t4_hold", 64'(bad), 64'd0);
    check("t4_busy_wait", 64'(eng_busy_o), 64'hE);
    eng_ready_i = 4'b0001;
    tick();
    check("t4_valid_clr", 64'(eng_valid_o), 64'h0);
    check("t4_disp", 64'(dispatched_cnt_o), 64'd6);
    check("t4_busy", 64'(eng_busy_o), 64'hF);

    // Done on a non-busy engine is not counted; enable low blocks pops.
    eng_done_i = 4'b0100;
    tick();
    eng_done_i = '0;
    check("t5_busy_pre", 64'(eng_busy_o), 64'hB);
    check("t5_idle_busy", 64'(idle_o), 64'h0);
    eng_done_i = 4'b1111;
    tick();
    eng_done_i = '0;
    check("t5_busy", 64'(eng_busy_o), 64'h0);
    check("t5_comp", 64'(completed_cnt_o), 64'd6);
    enable_i    = 1'b0;
    dsc_ready_i = 1'b1;
    dsc_data_i  = mk(9'h033, 16'h0055, 1'b1);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (dsc_pull_o) bad++;
      tick();
    end
    check("t5_nopull", 64'(bad), 64'd0);
    @(negedge clk);
    check("t5_idle", 64'(idle_o), 64'h1);
    tick();
    dsc_ready_i = 1'b0;

    // Reset while a transfer sits in S_SEND.
    enable_i    = 1'b1;
    eng_ready_i = 4'b1111;
    offer(mk(9'h011, 16'h0061, 1'b1), w);
    wait_valid(seen, lat);
    check("t6_valid_a", 64'(seen), 64'h2);
    tick();
    check("t6_disp", 64'(dispatched_cnt_o), 64'd7);
    eng_ready_i = '0;
    offer(mk(9'h012, 16'h0062, 1'b1), w);
    wait_valid(seen, lat);
    check("t6_valid_b", 64'(seen), 64'h4);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", 64'(eng_valid_o), 64'h0);
    check("t6_rst_busy",  64'(eng_busy_o), 64'h0);
    check("t6_rst_disp",  64'(dispatched_cnt_o), 64'h0);
    check("t6_rst_drop",  64'(dropped_cnt_o), 64'h0);
    check("t6_rst_comp",  64'(completed_cnt_o), 64'h0);
    check("t6_rst_idle",  64'(idle_o), 64'h1);
    check("t6_rst_pasid", 64'(eng_pasid_o), 64'h0);
    tick();
    resetn      = 1'b1;
    eng_ready_i = 4'b1111;
    offer(mk(9'h0C3, 16'h0077, 1'b1), w);
    wait_valid(seen, lat);
    check("t6_post_valid", 64'(seen), 64'h1);
    check("t6_post_pasid", 64'(eng_pasid_o), 64'h0C3);
    tick();
    check("t6_post_disp", 64'(dispatched_cnt_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
